// File: rtl/move_ctrl_pkg.sv
// Direction codes shared with the craft position block, plus the mask and
// round-robin helpers used by the move controller.
`ifndef MOVE_DIR_DEFINES
`define MOVE_DIR_DEFINES
`define UP    2'd0
`define DOWN  2'd1
`define LEFT  2'd2
`define RIGHT 2'd3
`endif

package move_ctrl_pkg;

  typedef logic [1:0] dir_t;

  localparam int unsigned NUM_BTN    = 4;
  localparam int unsigned CNT_W      = 8;
  localparam dir_t        DIR_RESET  = `UP;
  localparam dir_t        LAST_RESET = `RIGHT;

  // Opposing buttons held together cancel each other out.
  function automatic logic [NUM_BTN-1:0] eff_mask(input logic [NUM_BTN-1:0] st);
    logic [NUM_BTN-1:0] m;
    m = st;
    if (st[`UP] && st[`DOWN]) begin
      m[`UP]   = 1'b0;
      m[`DOWN] = 1'b0;
    end else begin
      m = m;
    end
    if (st[`LEFT] && st[`RIGHT]) begin
      m[`LEFT]  = 1'b0;
      m[`RIGHT] = 1'b0;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Walk from lowest to highest priority so the last hit is the winner:
  // offset 1 from last is the first choice, offset 4 (last itself) the final one.
  function automatic dir_t rr_pick(input logic [NUM_BTN-1:0] mask, input dir_t last);
    dir_t cand;
    dir_t win;
    win = last;
    for (int k = 4; k >= 1; k--) begin
      cand = dir_t'(last + dir_t'(k));
      if (mask[cand]) begin
        win = cand;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/move_ctrl_btn_debounce.sv
// One button: two-flop synchronizer followed by a saturating-free debounce
// counter that flips the debounced level after DEBOUNCE_CYCLES differing edges.
module btn_debounce
  import move_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_run,
  input  logic rst,
  input  logic btn_i,
  output logic state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             state_q;
  logic             state_d;

  // Counter clears whenever the synchronized level agrees with the debounced one.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = ~state_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/move_ctrl.sv
// Craft move controller: debounced direction buttons are paced into
// single-cycle move requests with round-robin direction arbitration.
module move_ctrl
  import move_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_PERIOD     = 4
) (
  input  logic         clk_run,
  input  logic         rst,
  input  logic [3:0]   btn_i,
  input  logic         moving_i,
  output logic         move_en_o,
  output logic [1:0]   direct_o,
  output logic [3:0]   btn_state_o,
  output logic         blocked_o
);

  localparam logic [CNT_W-1:0] PACE_LAST = CNT_W'(STEP_PERIOD - 1);

  logic [NUM_BTN-1:0] btn_state_s;
  logic [NUM_BTN-1:0] mask_s;
  logic               fire_s;
  dir_t               win_s;

  logic [CNT_W-1:0]   pace_q;
  logic [CNT_W-1:0]   pace_d;
  logic               move_en_q;
  logic               move_en_d;
  dir_t               direct_q;
  dir_t               direct_d;
  dir_t               last_dir_q;
  dir_t               last_dir_d;
  logic               pulse_dly_q;
  logic               pulse_dly_d;
  logic               blocked_q;
  logic               blocked_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_run (clk_run),
      .rst     (rst),
      .btn_i   (btn_i[g]),
      .state_o (btn_state_s[g])
    );
  end

  // Pacing, arbitration and boundary feedback next-state logic.
  always_comb begin
    mask_s      = eff_mask(btn_state_s);
    win_s       = rr_pick(mask_s, last_dir_q);
    fire_s      = (mask_s != 4'b0000) && (pace_q == '0);
    pace_d      = '0;
    move_en_d   = fire_s;
    direct_d    = direct_q;
    last_dir_d  = last_dir_q;
    pulse_dly_d = move_en_q;
    blocked_d   = blocked_q;

    if (mask_s == 4'b0000) begin
      pace_d = '0;
    end else if (pace_q == PACE_LAST) begin
      pace_d = '0;
    end else begin
      pace_d = pace_q + CNT_W'(1);
    end

    if (fire_s) begin
      direct_d   = win_s;
      last_dir_d = win_s;
    end else begin
      direct_d   = direct_q;
      last_dir_d = last_dir_q;
    end

    // Feedback for a step arrives one cycle after its request pulse.
    if (pulse_dly_q) begin
      blocked_d = ~moving_i;
    end else begin
      blocked_d = blocked_q;
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      pace_q      <= '0;
      move_en_q   <= 1'b0;
      direct_q    <= DIR_RESET;
      last_dir_q  <= LAST_RESET;
      pulse_dly_q <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      pace_q      <= pace_d;
      move_en_q   <= move_en_d;
      direct_q    <= direct_d;
      last_dir_q  <= last_dir_d;
      pulse_dly_q <= pulse_dly_d;
      blocked_q   <= blocked_d;
    end
  end

  assign move_en_o   = move_en_q;
  assign direct_o    = direct_q;
  assign btn_state_o = btn_state_s;
  assign blocked_o   = blocked_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl with DEBOUNCE_CYCLES=4, STEP_PERIOD=3; expected
// pulse directions are queued with the stimulus and popped as pulses appear.
module tb_move_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 3;

  logic       clk_run = 1'b0;
  logic       rst;
  logic [3:0] btn_i;
  logic       moving_i;
  logic       move_en_o;
  logic [1:0] direct_o;
  logic [3:0] btn_state_o;
  logic       blocked_o;

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         cyc        = 0;
  int         last_pulse = -1;
  logic [1:0] exp_q[$];

  move_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_PERIOD    (STEP)
  ) dut (
    .clk_run     (clk_run),
    .rst         (rst),
    .btn_i       (btn_i),
    .moving_i    (moving_i),
    .move_en_o   (move_en_o),
    .direct_o    (direct_o),
    .btn_state_o (btn_state_o),
    .blocked_o   (blocked_o)
  );

  always #5 clk_run = ~clk_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; any pulse is matched against the head of the scoreboard.
  task automatic tick();
    logic [1:0] d;
    @(posedge clk_run);
    #1;
    cyc++;
    if (move_en_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", {31'd0, move_en_o}, 32'd0);
      end else begin
        d = exp_q.pop_front();
        chk("pulse_dir", {30'd0, direct_o}, {30'd0, d});
        if (last_pulse >= 0) chk("pulse_gap", 32'(cyc - last_pulse), 32'(STEP));
        last_pulse = cyc;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(d);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; btn_i = 4'b0000; moving_i = 1'b1;
    ticks(3);
    chk("rst_move_en", {31'd0, move_en_o}, 32'd0);
    chk("rst_direct", {30'd0, direct_o}, 32'd0);
    chk("rst_btn_state", {28'd0, btn_state_o}, 32'd0);
    chk("rst_blocked", {31'd0, blocked_o}, 32'd0);
    rst = 1'b0;
    ticks(2);

    // Single UP hold: debounce latency, then pulses every STEP cycles
    last_pulse = -1;
    btn_i = 4'b0001;
    ticks(5);
    chk("up_state_before", {28'd0, btn_state_o}, 32'd0);
    tick();
    chk("up_state_after", {28'd0, btn_state_o}, 32'h1);
    push(2'd0, 4);
    ticks(10);
    btn_i = 4'b0000;
    push(2'd0, 2);
    ticks(10);
    chk("up_state_released", {28'd0, btn_state_o}, 32'd0);
    chk("up_queue", 32'(exp_q.size()), 32'd0);

    // Short bounce on LEFT is filtered out
    btn_i = 4'b0100;
    ticks(2);
    btn_i = 4'b0000;
    ticks(12);
    chk("bounce_state", {28'd0, btn_state_o}, 32'd0);

    // UP+LEFT alternate; last grant was UP so LEFT comes first
    last_pulse = -1;
    btn_i = 4'b0101;
    push(2'd2, 1); push(2'd0, 1); push(2'd2, 1); push(2'd0, 1);
    ticks(16);
    chk("rr_state", {28'd0, btn_state_o}, 32'h5);
    btn_i = 4'b0000;
    push(2'd2, 1); push(2'd0, 1);
    ticks(10);
    chk("rr_direct_hold", {30'd0, direct_o}, 32'd0);
    chk("rr_queue", 32'(exp_q.size()), 32'd0);

    // UP+DOWN cancel; adding LEFT yields LEFT only
    btn_i = 4'b0011;
    ticks(12);
    chk("cancel_state", {28'd0, btn_state_o}, 32'h3);
    last_pulse = -1;
    btn_i = 4'b0111;
    push(2'd2, 4);
    ticks(16);
    btn_i = 4'b0000;
    push(2'd2, 2);
    ticks(10);
    chk("cancel_direct_hold", {30'd0, direct_o}, 32'd2);
    chk("cancel_queue", 32'(exp_q.size()), 32'd0);

    // Boundary feedback sampled the cycle after a pulse
    last_pulse = -1;
    btn_i = 4'b0001;
    push(2'd0, 4);
    ticks(7);
    chk("blk_pulse_cycle", {31'd0, blocked_o}, 32'd0);
    tick();
    chk("blk_before_load", {31'd0, blocked_o}, 32'd0);
    moving_i = 1'b0;
    tick();
    chk("blk_set", {31'd0, blocked_o}, 32'd1);
    moving_i = 1'b1;
    tick();
    chk("blk_hold_pulse", {31'd0, blocked_o}, 32'd1);
    btn_i = 4'b0000;
    tick();
    chk("blk_hold_after", {31'd0, blocked_o}, 32'd1);
    tick();
    chk("blk_clear", {31'd0, blocked_o}, 32'd0);
    ticks(8);
    chk("blk_queue", 32'(exp_q.size()), 32'd0);

    // Reset while pulsing: asynchronous clear, then full debounce again
    last_pulse = -1;
    btn_i = 4'b0100;
    push(2'd2, 1);
    ticks(7);
    chk("pre_rst_pulse", {31'd0, move_en_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_move_en", {31'd0, move_en_o}, 32'd0);
    chk("mid_rst_direct", {30'd0, direct_o}, 32'd0);
    chk("mid_rst_btn_state", {28'd0, btn_state_o}, 32'd0);
    chk("mid_rst_blocked", {31'd0, blocked_o}, 32'd0);
    ticks(2);
    rst = 1'b0;
    last_pulse = -1;
    ticks(5);
    chk("post_rst_state_before", {28'd0, btn_state_o}, 32'd0);
    tick();
    chk("post_rst_state_after", {28'd0, btn_state_o}, 32'h4);
    push(2'd2, 1);
    tick();
    btn_i = 4'b0000;
    push(2'd2, 2);
    ticks(10);
    chk("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
